// File: rtl/isa_host_pkg.sv
// Shared command, status, control-bit and state definitions for the ISA host command port.
package isa_host_pkg;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BADCMD  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int CTL_READ  = 0;
  localparam int CTL_WRITE = 1;

  typedef enum logic [2:0] {
    GET_CMD  = 3'd0,
    GET_ALO  = 3'd1,
    GET_AHI  = 3'd2,
    GET_DATA = 3'd3,
    ISSUE    = 3'd4,
    WAIT_BUS = 3'd5
  } state_t;

  // One-hot request byte for control_out; bits 7:2 are never set.
  function automatic logic [7:0] ctl_request(input logic is_write);
    logic [7:0] ctl;
    ctl = 8'h00;
    if (is_write) ctl[CTL_WRITE] = 1'b1;
    else          ctl[CTL_READ]  = 1'b1;
    return ctl;
  endfunction

endpackage

// File: rtl/isa_host_command_port_strobe_sync.sv
// Brings the asynchronous host strobe into the clock_8MHz domain and flags its rising edge.
module host_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_8MHz,
  input  logic reset,
  input  logic host_strobe,
  output logic strobe_level,
  output logic strobe_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;

  always_ff @(posedge clock_8MHz or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], host_strobe};
      level_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe_level = sync_q[SYNC_STAGES-1];
  assign strobe_rise  = strobe_level & ~level_q;

endmodule

// File: rtl/isa_host_command_port.sv
// Host-side frame receiver that turns read/write byte frames into ISA bus requests
// and reports read data and completion status back to the host.
module isa_host_command_port
  import isa_host_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clock_8MHz,
  input  logic        reset,
  input  logic [7:0]  host_data_in,
  input  logic        host_strobe,
  output logic        host_ack,
  output logic        host_busy,
  output logic [7:0]  host_data_out,
  output logic [1:0]  host_status,
  output logic [7:0]  control_out,
  input  logic        control_reset,
  input  logic        data_load,
  output logic [15:0] isa_address,
  output logic [7:0]  isa_write_data,
  input  logic [7:0]  isa_read_data
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, state_d;
  logic               strobe_level, strobe_rise, byte_accept;
  logic               is_write, is_write_d;
  logic [15:0]        addr_reg, addr_reg_d;
  logic [7:0]         wdata_reg, wdata_reg_d;
  logic [7:0]         rd_buf, rd_buf_d;
  logic               rd_valid, rd_valid_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic               ack_d, busy_d;
  logic [7:0]         data_out_d, control_d, write_data_d;
  logic [1:0]         status_d;
  logic [15:0]        address_d;

  host_strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clock_8MHz   (clock_8MHz),
    .reset        (reset),
    .host_strobe  (host_strobe),
    .strobe_level (strobe_level),
    .strobe_rise  (strobe_rise)
  );

  // Bytes are only taken while the FSM is collecting a frame and the previous ack has dropped.
  assign byte_accept = strobe_rise && !host_ack &&
                       (state inside {GET_CMD, GET_ALO, GET_AHI, GET_DATA});

  always_ff @(posedge clock_8MHz or negedge reset) begin
    if (!reset) begin
      state          <= GET_CMD;
      is_write       <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rd_buf         <= '0;
      rd_valid       <= 1'b0;
      timer          <= '0;
      host_ack       <= 1'b0;
      host_busy      <= 1'b0;
      host_data_out  <= '0;
      host_status    <= ST_OK;
      control_out    <= '0;
      isa_address    <= '0;
      isa_write_data <= '0;
    end else begin
      state          <= state_d;
      is_write       <= is_write_d;
      addr_reg       <= addr_reg_d;
      wdata_reg      <= wdata_reg_d;
      rd_buf         <= rd_buf_d;
      rd_valid       <= rd_valid_d;
      timer          <= timer_d;
      host_ack       <= ack_d;
      host_busy      <= busy_d;
      host_data_out  <= data_out_d;
      host_status    <= status_d;
      control_out    <= control_d;
      isa_address    <= address_d;
      isa_write_data <= write_data_d;
    end
  end

  // The bus request is loaded on the final byte's capture edge, so control_out is
  // already high during the single ISSUE cycle.
  always_comb begin
    state_d      = state;
    is_write_d   = is_write;
    addr_reg_d   = addr_reg;
    wdata_reg_d  = wdata_reg;
    rd_buf_d     = rd_buf;
    rd_valid_d   = rd_valid;
    timer_d      = timer;
    busy_d       = host_busy;
    data_out_d   = host_data_out;
    status_d     = host_status;
    control_d    = control_out;
    address_d    = isa_address;
    write_data_d = isa_write_data;

    ack_d = host_ack;
    if (byte_accept)        ack_d = 1'b1;
    else if (!strobe_level) ack_d = 1'b0;

    case (state)
      GET_CMD: begin
        if (byte_accept) begin
          status_d = ST_OK;
          if (host_data_in == CMD_READ || host_data_in == CMD_WRITE) begin
            busy_d     = 1'b1;
            is_write_d = (host_data_in == CMD_WRITE);
            rd_valid_d = 1'b0;
            state_d    = GET_ALO;
          end else begin
            busy_d   = 1'b0;
            status_d = ST_BADCMD;
          end
        end
      end
      GET_ALO: begin
        if (byte_accept) begin
          addr_reg_d[7:0] = host_data_in;
          state_d         = GET_AHI;
        end
      end
      GET_AHI: begin
        if (byte_accept) begin
          addr_reg_d[15:8] = host_data_in;
          if (is_write) begin
            state_d = GET_DATA;
          end else begin
            address_d    = {host_data_in, addr_reg[7:0]};
            write_data_d = wdata_reg;
            control_d    = ctl_request(1'b0);
            state_d      = ISSUE;
          end
        end
      end
      GET_DATA: begin
        if (byte_accept) begin
          wdata_reg_d  = host_data_in;
          address_d    = addr_reg;
          write_data_d = host_data_in;
          control_d    = ctl_request(1'b1);
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        timer_d    = TIMER_W'(TIMEOUT_CYCLES);
        rd_valid_d = 1'b0;
        state_d    = WAIT_BUS;
      end
      WAIT_BUS: begin
        timer_d = (timer != '0) ? timer - TIMER_W'(1) : '0;
        if (!is_write && !data_load) begin
          rd_buf_d   = isa_read_data;
          rd_valid_d = 1'b1;
        end
        // Completion beats a simultaneous timeout; read data reaches the host only on success.
        if (!control_reset) begin
          if (!is_write) begin
            if (!data_load)    data_out_d = isa_read_data;
            else if (rd_valid) data_out_d = rd_buf;
          end
          control_d = '0;
          busy_d    = 1'b0;
          status_d  = ST_OK;
          state_d   = GET_CMD;
        end else if (timer <= TIMER_W'(1)) begin
          control_d = '0;
          busy_d    = 1'b0;
          status_d  = ST_TIMEOUT;
          state_d   = GET_CMD;
        end
      end
      default: state_d = GET_CMD;
    endcase
  end

endmodule

// File: tb/tb_isa_host_command_port.sv
// Directed-frame bench with an issue/completion scoreboard checked by an independent monitor.
module tb_isa_host_command_port;
  import isa_host_pkg::*;

  typedef struct {
    logic [7:0]  ctl;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        chk_wdata;
  } issue_t;

  typedef struct {
    logic [1:0] status;
    logic [7:0] dout;
    int         lat;
  } done_t;

  logic        clock_8MHz = 1'b0;
  logic        reset;
  logic [7:0]  host_data_in;
  logic        host_strobe;
  logic        host_ack;
  logic        host_busy;
  logic [7:0]  host_data_out;
  logic [1:0]  host_status;
  logic [7:0]  control_out;
  logic        control_reset;
  logic        data_load;
  logic [15:0] isa_address;
  logic [7:0]  isa_write_data;
  logic [7:0]  isa_read_data;

  isa_host_command_port #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clock_8MHz     (clock_8MHz),
    .reset          (reset),
    .host_data_in   (host_data_in),
    .host_strobe    (host_strobe),
    .host_ack       (host_ack),
    .host_busy      (host_busy),
    .host_data_out  (host_data_out),
    .host_status    (host_status),
    .control_out    (control_out),
    .control_reset  (control_reset),
    .data_load      (data_load),
    .isa_address    (isa_address),
    .isa_write_data (isa_write_data),
    .isa_read_data  (isa_read_data)
  );

  always #5 clock_8MHz = ~clock_8MHz;

  int cyc = 0;
  always @(posedge clock_8MHz) cyc <= cyc + 1;

  int     checks = 0;
  int     passes = 0;
  int     ack_count = 0;
  int     exp_acks = 0;
  int     last_ack_cyc = 0;
  int     issue_cyc = 0;
  int     tx_cyc = 0;
  logic   prev_ack = 1'b0;
  logic   prev_busy = 1'b0;
  logic [7:0] prev_ctl = 8'h00;
  issue_t issue_q[$];
  done_t  done_q[$];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: pops expectations when a request appears or a frame finishes.
  always @(negedge clock_8MHz) begin
    issue_t ei;
    done_t  ed;
    logic   ack_rise;
    if (reset) begin
      ack_rise = host_ack && !prev_ack;
      if (ack_rise) begin
        ack_count++;
        last_ack_cyc = cyc;
      end
      if (control_out != 8'h00 && prev_ctl == 8'h00) begin
        issue_cyc = cyc;
        if (issue_q.size() == 0) check_output("issue_unexpected", issue_q.size(), 1);
        else begin
          ei = issue_q.pop_front();
          check_output("issue_control_out", control_out, ei.ctl);
          check_output("issue_address", isa_address, ei.addr);
          if (ei.chk_wdata) check_output("issue_write_data", isa_write_data, ei.wdata);
          check_output("issue_busy", host_busy, 1);
          check_output("issue_status", host_status, ST_OK);
          check_output("issue_latency", cyc - last_ack_cyc, 0);
        end
      end
      if ((prev_busy && !host_busy) || (ack_rise && !host_busy)) begin
        if (done_q.size() == 0) check_output("done_unexpected", done_q.size(), 1);
        else begin
          ed = done_q.pop_front();
          check_output("done_status", host_status, ed.status);
          check_output("done_data_out", host_data_out, ed.dout);
          check_output("done_control_out", control_out, 8'h00);
          if (ed.lat >= 0) check_output("done_latency", cyc - issue_cyc, ed.lat);
        end
      end
    end
    prev_ack  = host_ack;
    prev_busy = host_busy;
    prev_ctl  = control_out;
  end

  // Sends one four-phase byte; hold extends the strobe after the ack is seen.
  task automatic apply_stimulus(input logic [7:0] data, input int hold, input bit expect_ack);
    host_data_in = data;
    host_strobe  = 1'b1;
    if (expect_ack) begin
      exp_acks++;
      for (int i = 0; i < 12 && !host_ack; i++) @(negedge clock_8MHz);
      check_output("ack_seen", host_ack, 1);
      tx_cyc = cyc;
      repeat (hold) @(negedge clock_8MHz);
      if (hold > 0) check_output("ack_held", host_ack, 1);
    end else begin
      repeat (6) @(negedge clock_8MHz);
    end
    host_strobe = 1'b0;
    for (int i = 0; i < 12 && host_ack; i++) @(negedge clock_8MHz);
    if (expect_ack) check_output("ack_release", host_ack, 0);
    @(negedge clock_8MHz);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock_8MHz);
  endtask

  task automatic pulse_control_reset(input int at);
    wait_until(at);
    control_reset = 1'b0;
    @(negedge clock_8MHz);
    control_reset = 1'b1;
  endtask

  task automatic pulse_data_load(input int at, input logic [7:0] value);
    wait_until(at);
    isa_read_data = value;
    data_load     = 1'b0;
    @(negedge clock_8MHz);
    data_load = 1'b1;
  endtask

  task automatic check_all_zero();
    check_output("zero_host_ack", host_ack, 0);
    check_output("zero_host_busy", host_busy, 0);
    check_output("zero_host_data_out", host_data_out, 0);
    check_output("zero_host_status", host_status, 0);
    check_output("zero_control_out", control_out, 0);
    check_output("zero_isa_address", isa_address, 0);
    check_output("zero_isa_write_data", isa_write_data, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    host_data_in  = 8'h00;
    host_strobe   = 1'b0;
    control_reset = 1'b1;
    data_load     = 1'b1;
    isa_read_data = 8'h00;
    repeat (3) @(negedge clock_8MHz);
    check_all_zero();
    reset = 1'b1;
    repeat (2) @(negedge clock_8MHz);

    // Write 0x5A to 0x0220; a data_load strobe during a write must not reach host_data_out.
    issue_q.push_back('{ctl: 8'h02, addr: 16'h0220, wdata: 8'h5A, chk_wdata: 1'b1});
    done_q.push_back('{status: ST_OK, dout: 8'h00, lat: 9});
    apply_stimulus(8'h02, 0, 1);
    apply_stimulus(8'h20, 0, 1);
    apply_stimulus(8'h02, 0, 1);
    apply_stimulus(8'h5A, 0, 1);
    pulse_data_load(tx_cyc + 4, 8'h33);
    pulse_control_reset(tx_cyc + 8);
    repeat (3) @(negedge clock_8MHz);

    // Read 0x022A with two captures; the later one (0xAA) must win.
    issue_q.push_back('{ctl: 8'h01, addr: 16'h022A, wdata: 8'h00, chk_wdata: 1'b0});
    done_q.push_back('{status: ST_OK, dout: 8'hAA, lat: 9});
    apply_stimulus(8'h01, 0, 1);
    apply_stimulus(8'h2A, 0, 1);
    apply_stimulus(8'h02, 0, 1);
    pulse_data_load(tx_cyc + 4, 8'h11);
    pulse_data_load(tx_cyc + 6, 8'hAA);
    pulse_control_reset(tx_cyc + 8);
    repeat (3) @(negedge clock_8MHz);

    // Bad command: acked, status 01, never busy.
    done_q.push_back('{status: ST_BADCMD, dout: 8'hAA, lat: -1});
    apply_stimulus(8'h7F, 0, 1);
    repeat (2) @(negedge clock_8MHz);
    check_output("badcmd_no_request", control_out, 8'h00);

    // Read with no completion: times out, previous read data kept; stray control_reset mid-frame ignored.
    issue_q.push_back('{ctl: 8'h01, addr: 16'h0300, wdata: 8'h00, chk_wdata: 1'b0});
    done_q.push_back('{status: ST_TIMEOUT, dout: 8'hAA, lat: 33});
    isa_read_data = 8'h55;
    apply_stimulus(8'h01, 0, 1);
    pulse_control_reset(cyc);
    apply_stimulus(8'h00, 0, 1);
    apply_stimulus(8'h03, 0, 1);
    for (int i = 0; i < 60 && host_busy; i++) @(negedge clock_8MHz);
    check_output("timeout_busy_low", host_busy, 0);
    repeat (3) @(negedge clock_8MHz);

    // Write, then a strobe during WAIT_BUS that must not be acked.
    issue_q.push_back('{ctl: 8'h02, addr: 16'h0140, wdata: 8'hC3, chk_wdata: 1'b1});
    done_q.push_back('{status: ST_OK, dout: 8'hAA, lat: 21});
    apply_stimulus(8'h02, 0, 1);
    apply_stimulus(8'h40, 0, 1);
    apply_stimulus(8'h01, 0, 1);
    apply_stimulus(8'hC3, 0, 1);
    apply_stimulus(8'hEE, 0, 0);
    check_output("no_ack_in_wait_bus", ack_count, exp_acks);
    pulse_control_reset(tx_cyc + 20);
    repeat (3) @(negedge clock_8MHz);

    // Reset after byte 2 of a write frame aborts it with everything cleared.
    apply_stimulus(8'h02, 0, 1);
    apply_stimulus(8'h11, 0, 1);
    apply_stimulus(8'h22, 0, 1);
    reset = 1'b0;
    repeat (2) @(negedge clock_8MHz);
    check_all_zero();
    reset = 1'b1;
    repeat (2) @(negedge clock_8MHz);

    // Fresh write with the command strobe held for 20 cycles: one byte only.
    issue_q.push_back('{ctl: 8'h02, addr: 16'h1234, wdata: 8'h99, chk_wdata: 1'b1});
    done_q.push_back('{status: ST_OK, dout: 8'h00, lat: 9});
    apply_stimulus(8'h02, 20, 1);
    apply_stimulus(8'h34, 0, 1);
    apply_stimulus(8'h12, 0, 1);
    apply_stimulus(8'h99, 0, 1);
    pulse_control_reset(tx_cyc + 8);
    repeat (5) @(negedge clock_8MHz);

    check_output("ack_count", ack_count, exp_acks);
    check_output("issue_queue_drained", issue_q.size(), 0);
    check_output("done_queue_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/isa_host_command_port.md
Name: isa_host_command_port

Overview:
- Upstream neighbour of the ISA bus cycle state machine on the CT2960 riser.
- Accepts byte frames from the host controller over an 8-bit, four-phase strobe/ack port.
- Latches the I/O address and write data, then raises the read or write request bit toward the bus state machine.
- Holds the request until the bus state machine's control_reset pulse, captures read data on its data_load strobe, and returns the result and status to the host.

Parameters:
- SYNC_STAGES, 2, flip-flop stages synchronising host_strobe into the clock_8MHz domain (minimum 2).
- TIMEOUT_CYCLES, 32, clock_8MHz cycles allowed from request issue to control_reset before abort.

Ports:
- clock_8MHz  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- host_data_in  input  8  frame byte from host; stable while host_strobe is high.
- host_strobe  input  1  asynchronous byte-valid strobe from host, active high.
- host_ack  output  1  byte accepted; held high until the synchronised strobe falls.
- host_busy  output  1  high from frame start until the bus cycle completes or aborts.
- host_data_out  output  8  last read data; valid while host_busy is low after a read.
- host_status  output  2  00 ok, 01 bad command, 10 bus timeout; cleared at the next frame start.
- control_out  output  8  to bus state machine control_in; bit0 read request, bit1 write request, bits 7:2 always 0.
- control_reset  input  1  active-low completion pulse from bus state machine.
- data_load  input  1  active-low read-data capture strobe from bus state machine.
- isa_address  output  16  latched I/O address.
- isa_write_data  output  8  latched write data.
- isa_read_data  input  8  ISA data bus (read path).

Behaviour:
- Reset: all outputs 0; state GET_CMD; internal registers 0. Reset mid-frame or mid-bus-cycle aborts immediately with no status recorded.
- Strobe path: host_strobe passes through SYNC_STAGES flops, then a rising-edge detect. A byte is captured in the cycle the edge is detected.
- host_ack rises the next cycle and stays high until the synchronised strobe is 0.
- Edges are ignored while host_ack is high, and in ISSUE/WAIT_BUS. No ack is given there.
- Frame format:
  - Byte 0: command. 0x01 = read, 0x02 = write.
  - Byte 1: address[7:0].
  - Byte 2: address[15:8].
  - Byte 3: write data, write command only.
- States:
  - GET_CMD: on a byte, set host_busy=1 and clear host_status.
    - 0x01 or 0x02: go to GET_ALO.
    - Any other value: host_status=01, host_busy=0, stay in GET_CMD. The byte is still acked.
  - GET_ALO: on a byte, store the low address byte, go to GET_AHI.
  - GET_AHI: on a byte, store the high address byte. Read goes to ISSUE; write goes to GET_DATA.
  - GET_DATA: on a byte, store the write data, go to ISSUE.
  - ISSUE: one cycle. Drive isa_address and isa_write_data from the stored registers. Set control_out[0] (read) or [1] (write). Load the timeout counter. Go to WAIT_BUS.
  - WAIT_BUS: hold control_out, isa_address and isa_write_data stable.
    - Read with data_load==0 at a clock edge: register isa_read_data into host_data_out. The last such capture wins.
    - control_reset==0: clear control_out, host_busy=0, host_status=00, go to GET_CMD.
    - Counter reaches 0 first: clear control_out, host_status=10, host_busy=0, go to GET_CMD. host_data_out is unchanged.
- Latency: the control_out bit is high 1 cycle after the final byte is captured. host_busy falls in the cycle after control_reset is sampled low.
- Simultaneous control_reset low and timeout expiry: completion wins, status 00.
- control_reset low outside WAIT_BUS: ignored.
- data_load low outside a read WAIT_BUS: ignored.
- host_data_out holds its value until the next successful read.
- Address and data registers are plain 16/8-bit stores; no arithmetic.
- Timeout counter: ceil(log2(TIMEOUT_CYCLES+1)) bits, decrements once per cycle in WAIT_BUS, saturates at 0.

Decomposition:
- Package isa_host_pkg holds:
  - command codes CMD_READ=8'h01 and CMD_WRITE=8'h02;
  - status codes ST_OK, ST_BADCMD, ST_TIMEOUT;
  - control bit indices CTL_READ=0 and CTL_WRITE=1;
  - the state encoding constants.
- Sub-module host_strobe_sync: SYNC_STAGES synchroniser plus rising-edge pulse and synchronised-level outputs. It is instantiated once.

Test Plan:
- Write frame 02,20,02,5A → isa_address=0x0220, isa_write_data=0x5A, control_out=0x02 one cycle after byte 3 capture. A model control_reset pulse 8 cycles later → control_out=0x00, host_busy=0, host_status=00.
- Read frame 01,2A,02 with isa_read_data=0xAA and data_load low 6 cycles after issue → control_out=0x01, then host_data_out=0xAA, status 00, busy low after control_reset.
- Bad command byte 0x7F → host_ack pulse, host_status=01, host_busy=0, no control_out activity. Next valid frame clears status to 00.
- No control_reset after issue → control_out cleared and host_status=10 exactly TIMEOUT_CYCLES cycles after entering WAIT_BUS; host_data_out keeps its previous value.
- Extra strobe during WAIT_BUS plus reset asserted mid-frame after byte 2 → no ack during WAIT_BUS. After reset all outputs are 0, and a fresh write frame completes normally.
- Strobe held high for 20 cycles → exactly one byte captured, and host_ack stays high until the strobe is released.
